multiboot_scheduler: RTL and testbench
======================================

Name: multiboot_scheduler

Overview:
- Arbitrates reboot requests from up to three core-side requesters: OSD menu, keyboard hotkey and core watchdog.
- Maps the winning request's slot index to a 24-bit SPI flash bitstream address.
- Quiesces the rest of the core, then drives the level REBOOT input of the multiboot/ICAP sequencer in the same clk_icap domain.
- Flags failure if the FPGA is still running after the reboot was issued.

Parameters:
SLOT0_ADDR, 24'h000000, SPI address for slot 0
SLOT1_ADDR, 24'h058000, SPI address for slot 1
SLOT2_ADDR, 24'h0B0000, SPI address for slot 2
SLOT3_ADDR, 24'h108000, SPI address for slot 3
GUARD_CYCLES, 1024, max cycles to wait for quiesce_ack (>=1)
PULSE_LEN, 16, cycles reboot held high (>=1)
TIMEOUT, 65536, cycles after pulse before declaring failure (>=8)

Ports:
clk_icap  in  1  ICAP clock; all logic on its rising edge
reset_n  in  1  synchronous, active-low reset
enable  in  1  global arm; requests accepted only while high in IDLE
req  in  3  per-requester request level; rising edge = request
req_slot  in  6  slot index per requester: req_slot[2i+1:2i] for requester i
quiesce_ack  in  1  core has stopped SDRAM/video activity
busy  out  1  high in every state except IDLE
grant  out  3  one-hot winning requester, held until return to IDLE
quiesce  out  1  request core to stop activity
spi_addr  out  24  selected bitstream address, stable from grant until IDLE
reboot  out  1  to multiboot REBOOT input
fail  out  1  sticky failure flag

Behaviour:
- Reset (reset_n low at a clock edge):
  - state=IDLE; busy=0, grant=0, quiesce=0, reboot=0, fail=0, spi_addr=SLOT0_ADDR.
  - Edge-detect registers cleared, so a req already high at reset release counts as an edge.
  - Reset mid-sequence aborts immediately; reboot drops the next cycle.
- Edge detect:
  - req_q <= req; req_q2 <= req_q; edge = req_q & ~req_q2.
  - If req rises before edge k, edge is high after edge k+1.
  - In IDLE with enable=1, grant/busy/spi_addr are valid after edge k+2.
- States: IDLE, QUIESCE, PULSE, WAIT, FAIL. All outputs are registered.
- IDLE:
  - If enable and edge!=0: the lowest index wins (req[0] highest); losers are dropped, not queued.
  - Latch slot = req_slot of the winner; spi_addr = SLOTn_ADDR; grant = one-hot; clear fail; load counter with GUARD_CYCLES-1; go to QUIESCE.
  - Edges in any other state, or with enable=0, are discarded.
- QUIESCE:
  - quiesce=1.
  - quiesce_ack high → load counter with PULSE_LEN-1 and go to PULSE. An ack already high on entry gives 1 cycle in QUIESCE.
  - Counter reaches 0 without ack → go to PULSE anyway (forced reboot). Total QUIESCE duration is GUARD_CYCLES cycles.
  - enable falling after leaving IDLE is ignored; the sequence is committed.
- PULSE:
  - reboot=1 for exactly PULSE_LEN cycles; quiesce stays 1.
  - Then reboot=0, load counter with TIMEOUT-1, go to WAIT.
  - The downstream detector needs reboot low for >=4 cycles after the high period; WAIT guarantees this.
- WAIT:
  - reboot=0, quiesce=1.
  - Normally the FPGA reconfigures here. If the counter reaches 0, go to FAIL.
- FAIL:
  - One cycle only: fail<=1; quiesce, grant and busy cleared on exit; go to IDLE.
  - spi_addr keeps its last value.
  - fail stays high until reset or the next accepted request.
- Counter: single down-counter, width clog2 of the largest count, never underflows (saturates at 0).
- reboot is never high outside PULSE; grant is always 0 or one-hot.

Test Plan:
- Reset, then req=3'b010 with req_slot[3:2]=2'd2, quiesce_ack tied 1 → grant=3'b010 and spi_addr=24'h0B0000 after 2 clocks; quiesce 1 for 1 cycle before reboot; reboot high exactly 16 cycles.
- Simultaneous req=3'b110 rising, slots 1 and 3 → grant=3'b010, spi_addr=24'h058000; req[2] never granted, even after it stays high.
- quiesce_ack held 0 → reboot rises after exactly 1024 QUIESCE cycles (forced path).
- After the pulse, no reconfiguration → fail=1 after 65536 WAIT cycles; busy=0, grant=0; a new req edge clears fail and restarts.
- enable=0 while req[0] rises → no state change, busy stays 0; enable dropped during PULSE → pulse completes unchanged.
- reset_n low on the 5th PULSE cycle → reboot=0, busy=0, spi_addr=24'h000000 next cycle; a req held high through reset release is accepted as a new request.

Source files
------------

// File: rtl/multiboot_scheduler.sv
// Multiboot reboot scheduler.
// Arbitrates reboot requests from three core-side requesters and maps the
// winner's slot to a SPI flash bitstream address. It then quiesces the core
// and drives a level REBOOT pulse into the ICAP multiboot sequencer. If the
// FPGA is still running once the timeout expires, it raises a sticky fail.
module multiboot_scheduler #(
  parameter logic [23:0] SLOT0_ADDR   = 24'h000000,
  parameter logic [23:0] SLOT1_ADDR   = 24'h058000,
  parameter logic [23:0] SLOT2_ADDR   = 24'h0B0000,
  parameter logic [23:0] SLOT3_ADDR   = 24'h108000,
  parameter int          GUARD_CYCLES = 1024,
  parameter int          PULSE_LEN    = 16,
  parameter int          TIMEOUT      = 65536
) (
  input  logic        clk_icap,
  input  logic        reset_n,
  input  logic        enable,
  input  logic [2:0]  req,
  input  logic [5:0]  req_slot,
  input  logic        quiesce_ack,
  output logic        busy,
  output logic [2:0]  grant,
  output logic        quiesce,
  output logic [23:0] spi_addr,
  output logic        reboot,
  output logic        fail
);

  // One counter serves all three timed phases, so it is sized for the largest load.
  localparam int MAX_AB = (GUARD_CYCLES > PULSE_LEN) ? GUARD_CYCLES : PULSE_LEN;
  localparam int MAX_N  = (MAX_AB > TIMEOUT) ? MAX_AB : TIMEOUT;
  localparam int CW     = (MAX_N <= 2) ? 1 : $clog2(MAX_N);

  localparam logic [CW-1:0] GUARD_LOAD = CW'(GUARD_CYCLES - 1);
  localparam logic [CW-1:0] PULSE_LOAD = CW'(PULSE_LEN - 1);
  localparam logic [CW-1:0] WAIT_LOAD  = CW'(TIMEOUT - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_QUIESCE,
    S_PULSE,
    S_WAIT,
    S_FAIL
  } state_t;

  state_t          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [2:0]      req_q, req_q2;
  logic [2:0]      edge_q, edge_d;
  logic [2:0]      grant_q, grant_d;
  logic [23:0]     spi_addr_q, spi_addr_d;
  logic            busy_q, busy_d;
  logic            quiesce_q, quiesce_d;
  logic            reboot_q, reboot_d;
  logic            fail_q, fail_d;

  logic [2:0]      win;
  logic [1:0]      win_slot;
  logic [23:0]     win_addr;

  // Priority pick among the fresh edges (req[0] highest) and the slot address lookup.
  always_comb begin
    win      = 3'b000;
    win_slot = 2'd0;
    if (edge_q[0]) begin
      win      = 3'b001;
      win_slot = req_slot[1:0];
    end else if (edge_q[1]) begin
      win      = 3'b010;
      win_slot = req_slot[3:2];
    end else if (edge_q[2]) begin
      win      = 3'b100;
      win_slot = req_slot[5:4];
    end
    case (win_slot)
      2'd0:    win_addr = SLOT0_ADDR;
      2'd1:    win_addr = SLOT1_ADDR;
      2'd2:    win_addr = SLOT2_ADDR;
      default: win_addr = SLOT3_ADDR;
    endcase
  end

  // Next-state logic. The outputs are derived from the next state so that each
  // registered output lines up with state_q.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    grant_d    = grant_q;
    spi_addr_d = spi_addr_q;
    fail_d     = fail_q;
    edge_d     = req_q & ~req_q2;

    case (state_q)
      S_IDLE: begin
        if (enable && (win != 3'b000)) begin
          grant_d    = win;
          spi_addr_d = win_addr;
          fail_d     = 1'b0;
          cnt_d      = GUARD_LOAD;
          state_d    = S_QUIESCE;
        end
      end
      S_QUIESCE: begin
        // Without an ack the guard expires and the reboot is forced anyway.
        if (quiesce_ack || (cnt_q == '0)) begin
          cnt_d   = PULSE_LOAD;
          state_d = S_PULSE;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      S_PULSE: begin
        if (cnt_q == '0) begin
          cnt_d   = WAIT_LOAD;
          state_d = S_WAIT;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      S_WAIT: begin
        // Normally the FPGA reconfigures here and this branch never completes.
        if (cnt_q == '0) begin
          fail_d  = 1'b1;
          state_d = S_FAIL;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      S_FAIL: begin
        grant_d = 3'b000;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    busy_d    = (state_d != S_IDLE);
    quiesce_d = (state_d != S_IDLE);
    reboot_d  = (state_d == S_PULSE);
  end

  // State, counter, edge detect and output registers with synchronous reset.
  always_ff @(posedge clk_icap) begin
    if (!reset_n) begin
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      req_q      <= 3'b000;
      req_q2     <= 3'b000;
      edge_q     <= 3'b000;
      grant_q    <= 3'b000;
      spi_addr_q <= SLOT0_ADDR;
      busy_q     <= 1'b0;
      quiesce_q  <= 1'b0;
      reboot_q   <= 1'b0;
      fail_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      req_q      <= req;
      req_q2     <= req_q;
      edge_q     <= edge_d;
      grant_q    <= grant_d;
      spi_addr_q <= spi_addr_d;
      busy_q     <= busy_d;
      quiesce_q  <= quiesce_d;
      reboot_q   <= reboot_d;
      fail_q     <= fail_d;
    end
  end

  assign busy     = busy_q;
  assign grant    = grant_q;
  assign quiesce  = quiesce_q;
  assign spi_addr = spi_addr_q;
  assign reboot   = reboot_q;
  assign fail     = fail_q;

endmodule

// File: tb/tb_multiboot_scheduler.sv
// Directed bench for multiboot_scheduler with default parameters.
// Inputs change 1ns after a rising edge, and outputs are sampled at the same point.
module tb_multiboot_scheduler;

  logic        clk_icap = 1'b0;
  logic        reset_n;
  logic        enable;
  logic [2:0]  req;
  logic [5:0]  req_slot;
  logic        quiesce_ack;
  logic        busy;
  logic [2:0]  grant;
  logic        quiesce;
  logic [23:0] spi_addr;
  logic        reboot;
  logic        fail;

  int checks   = 0;
  int failures = 0;
  int n;

  multiboot_scheduler dut (
    .clk_icap    (clk_icap),
    .reset_n     (reset_n),
    .enable      (enable),
    .req         (req),
    .req_slot    (req_slot),
    .quiesce_ack (quiesce_ack),
    .busy        (busy),
    .grant       (grant),
    .quiesce     (quiesce),
    .spi_addr    (spi_addr),
    .reboot      (reboot),
    .fail        (fail)
  );

  always #5 clk_icap = ~clk_icap;

  task automatic tick(input int cnt = 1);
    for (int i = 0; i < cnt; i++) begin
      @(posedge clk_icap);
      #1;
    end
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Counts the cycles reboot is high within a window that starts at the current sample.
  task automatic count_reboot(input int window, output int hi);
    hi = 0;
    for (int i = 0; i < window; i++) begin
      if (reboot === 1'b1) hi++;
      tick();
    end
  endtask

  task automatic do_reset();
    req     = 3'b000;
    reset_n = 1'b0;
    tick(2);
    reset_n = 1'b1;
  endtask

  initial begin
    reset_n     = 1'b0;
    enable      = 1'b0;
    req         = 3'b000;
    req_slot    = 6'b0;
    quiesce_ack = 1'b0;
    tick(3);
    check("rst_busy",    32'(busy),     32'd0);
    check("rst_grant",   32'(grant),    32'd0);
    check("rst_quiesce", 32'(quiesce),  32'd0);
    check("rst_reboot",  32'(reboot),   32'd0);
    check("rst_fail",    32'(fail),     32'd0);
    check("rst_addr",    32'(spi_addr), 32'h000000);

    // 1: requester 1, slot 2, ack already high.
    reset_n = 1'b1; enable = 1'b1; quiesce_ack = 1'b1;
    req_slot = 6'b00_10_00;
    req = 3'b010;
    tick(2);
    check("t1_grant_early", 32'(grant), 32'd0);
    tick();
    check("t1_grant",   32'(grant),    32'b010);
    check("t1_addr",    32'(spi_addr), 32'h0B0000);
    check("t1_busy",    32'(busy),     32'd1);
    check("t1_quiesce", 32'(quiesce),  32'd1);
    check("t1_reboot0", 32'(reboot),   32'd0);
    tick();
    check("t1_reboot1", 32'(reboot), 32'd1);
    count_reboot(40, n);
    check("t1_pulse_len", 32'(n), 32'd16);
    check("t1_wait_quiesce", 32'(quiesce), 32'd1);
    check("t1_wait_busy",    32'(busy),    32'd1);
    do_reset();

    // 2: simultaneous edges on requesters 1 and 2; requester 1 wins.
    req_slot = 6'b11_01_00;
    req = 3'b110;
    tick(3);
    check("t2_grant", 32'(grant),    32'b010);
    check("t2_addr",  32'(spi_addr), 32'h058000);
    tick(30);
    check("t2_grant_held", 32'(grant), 32'b010);
    do_reset();

    // 3: no ack, so the reboot is forced after the guard, then the timeout leads to fail.
    quiesce_ack = 1'b0;
    req_slot = 6'b00_00_11;
    req = 3'b001;
    tick(3);
    check("t3_grant", 32'(grant),    32'b001);
    check("t3_addr",  32'(spi_addr), 32'h108000);
    req = 3'b000;
    tick(1023);
    check("t3_guard_reboot0", 32'(reboot),  32'd0);
    check("t3_guard_quiesce", 32'(quiesce), 32'd1);
    tick();
    check("t3_forced_reboot", 32'(reboot), 32'd1);
    tick(16);
    check("t3_wait_reboot0", 32'(reboot), 32'd0);
    tick(65535);
    check("t3_fail_early", 32'(fail), 32'd0);
    check("t3_busy_wait",  32'(busy), 32'd1);
    tick();
    check("t3_fail_set", 32'(fail), 32'd1);
    tick();
    check("t3_idle_busy",    32'(busy),     32'd0);
    check("t3_idle_grant",   32'(grant),    32'd0);
    check("t3_idle_quiesce", 32'(quiesce),  32'd0);
    check("t3_fail_sticky",  32'(fail),     32'd1);
    check("t3_addr_kept",    32'(spi_addr), 32'h108000);
    tick(5);
    check("t3_fail_sticky2", 32'(fail), 32'd1);
    quiesce_ack = 1'b1;
    req_slot = 6'b10_00_00;
    req = 3'b100;
    tick(3);
    check("t3_regrant",   32'(grant),    32'b100);
    check("t3_fail_clr",  32'(fail),     32'd0);
    check("t3_readdr",    32'(spi_addr), 32'h0B0000);
    do_reset();

    // 4: requests with enable low are ignored; dropping enable mid-pulse has no effect.
    enable = 1'b0;
    req_slot = 6'b00_00_01;
    req = 3'b001;
    tick(5);
    check("t4_dis_busy",  32'(busy),  32'd0);
    check("t4_dis_grant", 32'(grant), 32'd0);
    req = 3'b000;
    tick(2);
    enable = 1'b1;
    tick(3);
    check("t4_stale_busy", 32'(busy), 32'd0);
    req = 3'b001;
    tick(3);
    check("t4_grant", 32'(grant),    32'b001);
    check("t4_addr",  32'(spi_addr), 32'h058000);
    tick();
    check("t4_reboot1", 32'(reboot), 32'd1);
    enable = 1'b0;
    count_reboot(40, n);
    check("t4_pulse_len", 32'(n), 32'd16);
    check("t4_busy_after", 32'(busy), 32'd1);
    enable = 1'b1;
    do_reset();

    // 5: reset on the 5th pulse cycle; a req held through reset release is a new request.
    req_slot = 6'b00_01_00;
    req = 3'b010;
    tick(3);
    check("t5_grant", 32'(grant), 32'b010);
    tick(5);
    check("t5_reboot_p5", 32'(reboot), 32'd1);
    reset_n = 1'b0;
    tick();
    check("t5_rst_reboot", 32'(reboot),   32'd0);
    check("t5_rst_busy",   32'(busy),     32'd0);
    check("t5_rst_grant",  32'(grant),    32'd0);
    check("t5_rst_addr",   32'(spi_addr), 32'h000000);
    reset_n = 1'b1;
    tick(2);
    check("t5_regrant_early", 32'(grant), 32'd0);
    tick();
    check("t5_regrant", 32'(grant),    32'b010);
    check("t5_readdr",  32'(spi_addr), 32'h058000);
    check("t5_rebusy",  32'(busy),     32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
